// File: rtl/video_pointer_ctrl.sv
// Hardware pointer: shadowed position/enable regs committed at frame_start,
// per-pixel window compare driving the pointer bitmap address.
// Ports: clk, reset (async, active-high), x/y/visible beam inputs,
//   frame_start pulse, reg_wr/reg_addr/reg_wdata/reg_ack CPU write port,
//   update_pending, pointer_x/pointer_y/pointer_active (registered, 1 clk).
// Option: define POINTER_HOTSPOT_EN to store and apply the hotspot reg (addr 3).
module video_pointer_ctrl #(
  parameter int PTR_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         x,
  input  logic [15:0]         y,
  input  logic                visible,
  input  logic                frame_start,
  input  logic                reg_wr,
  input  logic [1:0]          reg_addr,
  input  logic [15:0]         reg_wdata,
  output logic                reg_ack,
  output logic                update_pending,
  output logic [PTR_BITS:0]   pointer_x,
  output logic [PTR_BITS:0]   pointer_y,
  output logic                pointer_active
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } state_t;

  state_t state;

  logic [15:0] sh_x, sh_y, lv_x, lv_y;
  logic        sh_en, lv_en;
  logic [3:0]  hx, hy;

`ifdef POINTER_HOTSPOT_EN
  logic [7:0] sh_hot, lv_hot;
  assign hx = lv_hot[3:0];
  assign hy = lv_hot[7:4];
`else
  assign hx = 4'd0;
  assign hy = 4'd0;
`endif

  logic accept, commit;

  // Writes stall in COMMIT; while an ack is out the request is not resampled.
  assign accept = reg_wr & ~reg_ack & (state != COMMIT);
  // Live regs latch at the frame_start edge, so a write accepted on the
  // same edge lands only in shadow and waits for the next frame.
  assign commit = (state == PENDING) & frame_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      reg_ack        <= 1'b0;
      update_pending <= 1'b0;
      sh_x           <= '0;
      sh_y           <= '0;
      sh_en          <= 1'b0;
      lv_x           <= '0;
      lv_y           <= '0;
      lv_en          <= 1'b0;
`ifdef POINTER_HOTSPOT_EN
      sh_hot         <= '0;
      lv_hot         <= '0;
`endif
    end else begin
      reg_ack <= accept;
      if (accept) begin
        case (reg_addr)
          2'd0: sh_x  <= reg_wdata;
          2'd1: sh_y  <= reg_wdata;
          2'd2: sh_en <= reg_wdata[0];
`ifdef POINTER_HOTSPOT_EN
          2'd3: sh_hot <= reg_wdata[7:0];
`endif
          default: ;
        endcase
      end
      if (commit) begin
        lv_x  <= sh_x;
        lv_y  <= sh_y;
        lv_en <= sh_en;
`ifdef POINTER_HOTSPOT_EN
        lv_hot <= sh_hot;
`endif
      end
      if (commit)
        update_pending <= accept;
      else if (accept)
        update_pending <= 1'b1;
      unique case (state)
        IDLE:    if (accept) state <= PENDING;
        PENDING: if (frame_start) state <= COMMIT;
        COMMIT:  state <= update_pending ? PENDING : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [16:0] ox, oy, dx, dy;
  logic        in_win;

  // 17-bit math keeps a pointer near 0xFFFF from wrapping to x=0.
  always_comb begin
    ox = {1'b0, lv_x} - {13'd0, hx};
    oy = {1'b0, lv_y} - {13'd0, hy};
    dx = {1'b0, x} - ox;
    dy = {1'b0, y} - oy;
    in_win = visible & lv_en
           & ~|dx[16:PTR_BITS]
           & ~|dy[16:PTR_BITS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer_active <= 1'b0;
      pointer_x      <= '0;
      pointer_y      <= '0;
    end else begin
      pointer_active <= in_win;
      pointer_x <= in_win ? {1'b0, dx[PTR_BITS-1:0]} : '0;
      pointer_y <= in_win ? {1'b0, dy[PTR_BITS-1:0]} : '0;
    end
  end

endmodule

// File: tb/tb_video_pointer_ctrl.sv
// Bench for video_pointer_ctrl: scoreboarded pixel outputs against a
// shadow/live register model, plus handshake and window boundary checks.
module tb_video_pointer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y;
  logic        visible, frame_start, reg_wr;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack, update_pending, pointer_active;
  logic [4:0]  pointer_x, pointer_y;

  video_pointer_ctrl #(.PTR_BITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .y(y),
    .visible(visible),
    .frame_start(frame_start),
    .reg_wr(reg_wr),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_ack(reg_ack),
    .update_pending(update_pending),
    .pointer_x(pointer_x),
    .pointer_y(pointer_y),
    .pointer_active(pointer_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hits    = 0;
  logic [10:0] sbq[$];
  int sh[4];
  int lv[4];
  bit m_pend;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model(int bx, int by, bit vis);
    int hx, hy, dx, dy;
    logic [4:0] px, py;
`ifdef POINTER_HOTSPOT_EN
    hx = lv[3] & 15;
    hy = (lv[3] >> 4) & 15;
`else
    hx = 0;
    hy = 0;
`endif
    dx = bx - (lv[0] - hx);
    dy = by - (lv[1] - hy);
    px = 5'(dx);
    py = 5'(dy);
    if (vis && lv[2][0] && dx >= 0 && dx < 16 && dy >= 0 && dy < 16)
      return {1'b1, px, py};
    return 11'd0;
  endfunction

  task automatic tick();
    logic [10:0] e;
    bit fs_s, pend_s, wr_s;
    int bx, by;
    fs_s   = frame_start;
    pend_s = m_pend;
    wr_s   = reg_wr;
    bx     = int'(x);
    by     = int'(y);
    sbq.push_back(model(bx, by, visible));
    @(posedge clk);
    #1;
    if (fs_s && pend_s) begin
      for (int i = 0; i < 4; i++) lv[i] = sh[i];
      m_pend = 0;
    end
    if (reg_ack) begin
      sh[reg_addr] = (reg_addr == 2'd2) ? int'(reg_wdata[0])
                   : int'(reg_wdata);
`ifndef POINTER_HOTSPOT_EN
      if (reg_addr == 2'd3) sh[3] = 0;
`endif
      m_pend = 1;
    end
    e = sbq.pop_front();
    check($sformatf("pix@%0d,%0d", bx, by),
          {pointer_active, pointer_x, pointer_y}, e);
    check("pend", update_pending, m_pend);
    check("ack_spur", reg_ack & ~wr_s, 0);
    if (pointer_active) hits++;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d,
                           output int lat);
    int n;
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!reg_ack && n < 4);
    check("ack_seen", reg_ack, 1);
    check("ack_lat", n <= 2, 1);
    reg_wr = 1'b0;
    lat = n;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    int l;
    cpu_write(a, d, l);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic sweep(int x0, int x1, int y0, int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) begin
        x = 16'(xx);
        y = 16'(yy);
        visible = 1'b1;
        tick();
      end
    visible = 1'b0;
  endtask

  initial begin
    int lat, n;
    for (int i = 0; i < 4; i++) begin
      sh[i] = 0;
      lv[i] = 0;
    end
    m_pend = 0;
    reset = 1'b1;
    x = '0; y = '0;
    visible = 1'b0; frame_start = 1'b0;
    reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", reg_ack, 0);
    check("rst_pend", update_pending, 0);
    check("rst_act", pointer_active, 0);
    check("rst_pxy", {pointer_x, pointer_y}, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: nothing enabled
    frame();
    hits = 0;
    sweep(0, 39, 0, 3);
    check("t1_hits", hits, 0);
    check("t1_ack", reg_ack, 0);

    // 2: basic window
    wr(2'd0, 16'd100);
    wr(2'd1, 16'd50);
    wr(2'd2, 16'd1);
    check("t2_pend", update_pending, 1);
    frame();
    check("t2_pend_clr", update_pending, 0);
    hits = 0;
    sweep(96, 120, 48, 68);
    check("t2_hits", hits, 256);
    x = 16'd103; y = 16'd52; visible = 1'b1;
    tick();
    check("t2_px", pointer_x, 3);
    check("t2_py", pointer_y, 2);
    check("t2_act", pointer_active, 1);
    visible = 1'b0;

    // 3: mid-frame write does not move the window
    wr(2'd0, 16'd200);
    hits = 0;
    sweep(96, 120, 50, 52);
    check("t3_old_hits", hits, 48);
    frame();
    hits = 0;
    sweep(196, 220, 50, 50);
    check("t3_new_hits", hits, 16);

    // 4: write on the frame_start cycle
    wr(2'd0, 16'd300);
    tick();
    reg_wr = 1'b1; reg_addr = 2'd1; reg_wdata = 16'd60;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 1;
    while (!reg_ack && n < 4) begin
      tick();
      n++;
    end
    reg_wr = 1'b0;
    check("t4_ack_lat", n <= 2, 1);
    check("t4_pend", update_pending, 1);
    hits = 0;
    sweep(296, 320, 50, 50);
    check("t4_oldy_hits", hits, 16);
    frame();
    cpu_write(2'd0, 16'd300, lat);
    check("t4_hold_lat", lat, 2);
    frame();
    check("t4_pend_clr", update_pending, 0);
    hits = 0;
    sweep(296, 320, 58, 62);
    check("t4_newy_hits", hits, 48);

    // 5: right-edge clip, no wrap
    wr(2'd0, 16'hFFF8);
    wr(2'd1, 16'd0);
    frame();
    hits = 0;
    sweep(16'hFFF0, 16'hFFFF, 0, 1);
    check("t5_edge_hits", hits, 16);
    hits = 0;
    sweep(0, 9, 0, 1);
    check("t5_wrap_hits", hits, 0);

    // 6: hotspot
    wr(2'd0, 16'd4);
    wr(2'd1, 16'd4);
    wr(2'd3, 16'h0088);
    frame();
    x = 16'd0; y = 16'd0; visible = 1'b1;
    tick();
`ifdef POINTER_HOTSPOT_EN
    check("t6_act", pointer_active, 1);
    check("t6_px", pointer_x, 4);
    check("t6_py", pointer_y, 4);
`else
    check("t6_act", pointer_active, 0);
    x = 16'd4; y = 16'd4;
    tick();
    check("t6_act4", pointer_active, 1);
    check("t6_px4", pointer_x, 0);
`endif
    visible = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
